svc_uart_rx_mon: RTL and testbench
==================================

SVC_UART_RX_MON -- requirements
Module: svc_uart_rx_mon

Interface
REQ-001 SHALL have parameter CLOCK_FREQ_MHZ, default 25: system clock frequency in MHz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200: serial bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, power of two, at least 2: receive buffer depth in bytes.
REQ-004 SHALL have parameter EOT_CHAR, default 8'h04: end-of-test marker byte.
REQ-005 SHALL have port clk, input, 1: the single clock.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port urx, input, 1: serial line driven by the SoC uart_tx; idles high.
REQ-008 SHALL have port m_valid, output, 1: a received byte is available.
REQ-009 SHALL have port m_data, output, 8: the received byte at the FIFO head.
REQ-010 SHALL have port m_ready, input, 1: the consumer accepts the byte.
REQ-011 SHALL have port framing_err, output, 1: sticky flag, a stop bit was sampled low.
REQ-012 SHALL have port overflow, output, 1: sticky flag, a byte was dropped because the FIFO was full.
REQ-013 SHALL have port eot, output, 1: sticky flag, EOT_CHAR was received.
REQ-014 SHALL have port rx_count, output, 32: count of bytes accepted into the FIFO, wrapping at 2^32.

Function
REQ-015 SHALL define CLKS_PER_BIT = (CLOCK_FREQ_MHZ*1_000_000)/BAUD_RATE using integer division, and SHALL require CLKS_PER_BIT >= 4.
REQ-016 SHALL pass urx through a 2-flop synchronizer; all decoding SHALL use the synchronized value.
REQ-017 SHALL implement a state machine with states IDLE, START, DATA and STOP.
REQ-018 In IDLE, a synchronized high-to-low transition SHALL move the FSM to START and load the bit counter with CLKS_PER_BIT/2 - 1.
REQ-019 In START, when the counter expires the line SHALL be sampled.
- Sample low: go to DATA.
- Sample high: treat as a glitch, return to IDLE, no flags set.
REQ-020 In DATA, the line SHALL be sampled every CLKS_PER_BIT cycles, 8 samples, shifted in LSB first; after the 8th sample the FSM SHALL go to STOP.
REQ-021 In STOP, the line SHALL be sampled CLKS_PER_BIT cycles after the 8th data sample.
- Sample high: the byte SHALL be offered to the FIFO and the FSM SHALL return to IDLE.
- Sample low: framing_err SHALL be set, the byte SHALL be discarded, and the FSM SHALL wait in STOP until the line is high before entering IDLE.
REQ-022 A push SHALL occur on the cycle after the stop sample; m_valid SHALL be asserted on the cycle after the push, with m_data valid while m_valid is high.
REQ-023 The output SHALL follow the valid/ready rules:
- A pop occurs when m_valid && m_ready.
- m_data SHALL be stable while m_valid is high and m_ready is low.
- m_valid SHALL NOT drop without a pop.
REQ-024 A push into a full FIFO SHALL drop the byte and set overflow, except when a pop occurs in the same cycle, in which case the push SHALL be accepted.
REQ-025 rx_count SHALL increment only on accepted pushes.
REQ-026 eot SHALL set when a byte equal to EOT_CHAR is accepted; that byte SHALL still be pushed into the FIFO.
REQ-027 Sticky flags SHALL clear only on reset.
REQ-028 The receiver SHALL keep decoding regardless of FIFO state or m_ready.

Reset
REQ-029 On rst_n low, all state SHALL take its reset value asynchronously:
- FSM to IDLE.
- FIFO empty, so m_valid = 0.
- m_data = 0.
- framing_err = 0, overflow = 0, eot = 0.
- rx_count = 0.
- Synchronizer flops to 1.
REQ-030 Reset asserted mid-frame SHALL abandon the frame without pushing or flagging; after rst_n rises, a line still low SHALL NOT be taken as a start bit until it has first been seen high.

Verification (CLOCK_FREQ_MHZ=1, BAUD_RATE=250_000, so CLKS_PER_BIT=4; FIFO_DEPTH=4)
REQ-031 Send 8'hA5 with m_ready=1 -> one m_valid pulse with m_data=8'hA5, rx_count=1, no flags set.
REQ-032 Send 8'h04 -> eot=1 and m_data=8'h04; eot stays 1 after further bytes until reset.
REQ-033 Hold m_ready=0 and send 5 bytes 01..05 -> overflow=1, rx_count=4; draining yields 01,02,03,04.
REQ-034 Send a frame with the stop bit low, then hold the line high, then send 8'h3C -> framing_err=1, the bad byte is absent, and 8'h3C is delivered.
REQ-035 Drive a 1-cycle low glitch on the idle line -> no push and no flags set.
REQ-036 Assert rst_n during DATA of byte 8'hFF -> all outputs at reset values; the next full frame 8'h12 is received correctly.

Source files
------------

// File: rtl/svc_uart_rx_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : svc_uart_rx_mon                                            |
// | Description : UART receive monitor. Decodes 8N1 frames from the SoC      |
// |               uart_tx line and buffers them in a small FIFO behind a     |
// |               valid/ready output. It also keeps sticky framing-error,    |
// |               overflow and end-of-test flags and a count of accepted     |
// |               bytes.                                                     |
// | Ports       : clk, rst_n (async, active-low)                             |
// |               urx                 - serial input, idles high             |
// |               m_valid/m_data/m_ready - byte stream out of the FIFO head  |
// |               framing_err, overflow, eot - sticky status flags           |
// |               rx_count            - bytes accepted into the FIFO         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module svc_uart_rx_mon #(
    parameter int         CLOCK_FREQ_MHZ = 25,
    parameter int         BAUD_RATE      = 115_200,
    parameter int         FIFO_DEPTH     = 16,
    parameter logic [7:0] EOT_CHAR       = 8'h04
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        urx,
    output logic        m_valid,
    output logic [7:0]  m_data,
    input  logic        m_ready,
    output logic        framing_err,
    output logic        overflow,
    output logic        eot,
    output logic [31:0] rx_count
);

    localparam int c_clks_per_bit = (CLOCK_FREQ_MHZ * 1_000_000) / BAUD_RATE;
    // Largest reload value is c_clks_per_bit-1, which always fits in clog2 bits.
    localparam int c_cnt_w = $clog2(c_clks_per_bit);
    localparam logic [c_cnt_w-1:0] c_full_reload = c_cnt_w'(c_clks_per_bit - 1);
    localparam logic [c_cnt_w-1:0] c_half_reload = c_cnt_w'(c_clks_per_bit / 2 - 1);
    localparam int c_aw = $clog2(FIFO_DEPTH);
    localparam logic [c_aw:0] c_depth_cnt = (c_aw + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    if (c_clks_per_bit < 4) begin : g_cpb_check
        $error("svc_uart_rx_mon: CLKS_PER_BIT must be at least 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
        $error("svc_uart_rx_mon: FIFO_DEPTH must be a power of two >= 2");
    end

    // ---------------- synchronizer and start-edge detect ----------------
    logic       r_sync1, r_sync2;
    logic [1:0] r_sync_vld;
    logic       r_prev;
    logic       w_rx, w_fall;

    // r_sync_vld marks when r_sync2 holds a real line sample rather than its
    // reset value; r_prev is only set by a real high sample, so a line that
    // is low when reset releases cannot masquerade as a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync_vld <= 2'b00;
            r_prev     <= 1'b0;
        end else begin
            r_sync1    <= urx;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_prev     <= r_sync_vld[1] & r_sync2;
        end
    end

    assign w_rx   = r_sync2;
    assign w_fall = r_prev & ~w_rx & r_sync_vld[1];

    // ---------------- receive FSM ----------------
    logic [1:0]         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_stop_bad;
    logic               w_tick, w_load_half, w_load_full, w_shift, w_stop_ok, w_stop_bad;

    assign w_tick = (r_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_st_idle;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle:  if (w_fall) w_state_nxt = c_st_start;
            c_st_start: if (w_tick) w_state_nxt = w_rx ? c_st_idle : c_st_data;
            c_st_data:  if (w_tick && r_bit_idx == 3'd7) w_state_nxt = c_st_stop;
            c_st_stop: begin
                // After a bad stop bit, hold here until the line returns high.
                if (r_stop_bad) begin
                    if (w_rx) w_state_nxt = c_st_idle;
                end else if (w_tick && w_rx) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default:    w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        w_load_half = (r_state == c_st_idle) && w_fall;
        w_load_full = ((r_state == c_st_start) && w_tick && !w_rx) ||
                      ((r_state == c_st_data) && w_tick);
        w_shift     = (r_state == c_st_data) && w_tick;
        w_stop_ok   = (r_state == c_st_stop) && !r_stop_bad && w_tick && w_rx;
        w_stop_bad  = (r_state == c_st_stop) && !r_stop_bad && w_tick && !w_rx;
    end

    logic       r_push;
    logic [7:0] r_push_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_stop_bad  <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 8'h00;
        end else begin
            if (w_load_half)      r_cnt <= c_half_reload;
            else if (w_load_full) r_cnt <= c_full_reload;
            else if (!w_tick)     r_cnt <= r_cnt - c_cnt_w'(1);

            if (w_load_half)  r_bit_idx <= 3'd0;
            else if (w_shift) r_bit_idx <= r_bit_idx + 3'd1;

            if (w_shift) r_shift <= {w_rx, r_shift[7:1]};

            if (w_stop_bad)                  r_stop_bad <= 1'b1;
            else if (r_state == c_st_idle)   r_stop_bad <= 1'b0;

            r_push      <= w_stop_ok;
            r_push_data <= r_shift;
        end
    end

    // ---------------- receive FIFO and status ----------------
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_pop, w_full, w_accept;

    assign m_valid  = (r_count != '0);
    assign m_data   = r_mem[r_rd_ptr];
    assign w_pop    = m_valid & m_ready;
    assign w_full   = (r_count == c_depth_cnt);
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_accept = r_push & (~w_full | w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= 8'h00;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            framing_err <= 1'b0;
            overflow    <= 1'b0;
            eot         <= 1'b0;
            rx_count    <= 32'd0;
        end else begin
            if (w_accept) begin
                r_mem[r_wr_ptr] <= r_push_data;
                r_wr_ptr        <= r_wr_ptr + c_aw'(1);
                rx_count        <= rx_count + 32'd1;
                if (r_push_data == EOT_CHAR) eot <= 1'b1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_aw'(1);

            if (w_accept && !w_pop)      r_count <= r_count + (c_aw + 1)'(1);
            else if (!w_accept && w_pop) r_count <= r_count - (c_aw + 1)'(1);

            if (r_push && !w_accept) overflow    <= 1'b1;
            if (w_stop_bad)          framing_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_svc_uart_rx_mon.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_svc_uart_rx_mon                                         |
// | Description : Self-checking bench for svc_uart_rx_mon at 4 clocks/bit    |
// |               with a 4-entry FIFO. Expected byte streams and counters    |
// |               come from a frame-level model of the receiver.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_svc_uart_rx_mon;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        urx = 1'b1;
    logic        m_ready = 1'b0;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        framing_err, overflow, eot;
    logic [31:0] rx_count;

    int checks = 0;
    int errors = 0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    bit b2b_done;

    svc_uart_rx_mon #(
        .CLOCK_FREQ_MHZ(1),
        .BAUD_RATE     (250_000),
        .FIFO_DEPTH    (DEPTH),
        .EOT_CHAR      (8'h04)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .urx        (urx),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .framing_err(framing_err),
        .overflow   (overflow),
        .eot        (eot),
        .rx_count   (rx_count)
    );

    always #5 clk = ~clk;

    // Output monitor, sampled on the falling edge: collects popped bytes and
    // checks that a stalled byte holds its value until it is taken.
    initial begin
        logic       hold;
        logic [7:0] hold_data;
        hold = 1'b0;
        hold_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    checks++;
                    if (m_valid !== 1'b1 || m_data !== hold_data) begin
                        errors++;
                        $display("FAIL hold_stable: got valid=%b data=%h, want valid=1 data=%h",
                                 m_valid, m_data, hold_data);
                    end
                end
                if (m_valid && m_ready) got_q.push_back(m_data);
                hold = m_valid && !m_ready;
                hold_data = m_data;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        urx = v;
        cycles(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        if (stop) urx = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
    endtask

    function automatic logic [7:0] rand_non_eot();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'h04) b = 8'h40;
        return b;
    endfunction

    task automatic test_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({m_valid, m_data, framing_err, overflow, eot, rx_count} !== 44'd0) begin
            errors++;
            $display("FAIL reset_values: got valid=%b data=%h fe=%b ov=%b eot=%b cnt=%0d, want all 0",
                     m_valid, m_data, framing_err, overflow, eot, rx_count);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(4);
    endtask

    task automatic test_single();
        m_ready = 1'b1;
        got_q.delete();
        send_frame(8'hA5, 1'b1);
        cycles(8);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
            errors++;
            $display("FAIL single_byte: got %0d bytes (first %h), want 1 byte a5",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx);
        end
        checks++;
        if (rx_count !== 32'd1) begin
            errors++;
            $display("FAIL single_count: got %0d, want 1", rx_count);
        end
        checks++;
        if ({framing_err, overflow, eot, m_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL single_flags: got fe=%b ov=%b eot=%b valid=%b, want 0",
                     framing_err, overflow, eot, m_valid);
        end
    endtask

    // Back-to-back frames with a randomly stalling consumer. Bytes arrive far
    // slower than a half-ready consumer drains them, so the model is simply
    // that every byte comes out, in order.
    task automatic test_back_to_back();
        int n;
        int unsigned cnt0;
        n = 10;
        cnt0 = rx_count;
        got_q.delete();
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(rand_non_eot());
        b2b_done = 1'b0;
        fork
            begin
                for (int i = 0; i < n; i++) send_frame(exp_q[i], 1'b1);
                b2b_done = 1'b1;
            end
            begin
                while (!b2b_done) begin
                    @(posedge clk);
                    #1;
                    m_ready = 1'($urandom);
                end
            end
        join
        m_ready = 1'b1;
        cycles(10);
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL b2b_size: got %0d bytes, want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL b2b_byte[%0d]: got %h, want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (rx_count !== cnt0 + 32'(n)) begin
            errors++;
            $display("FAIL b2b_count: got %0d, want %0d", rx_count, cnt0 + 32'(n));
        end
        checks++;
        if ({framing_err, overflow, eot} !== 3'b000) begin
            errors++;
            $display("FAIL b2b_flags: got fe=%b ov=%b eot=%b, want 0", framing_err, overflow, eot);
        end
    endtask

    task automatic test_eot();
        int unsigned cnt0;
        cnt0 = rx_count;
        m_ready = 1'b1;
        got_q.delete();
        send_frame(8'h04, 1'b1);
        cycles(8);
        checks++;
        if (eot !== 1'b1 || got_q.size() != 1 || got_q[0] !== 8'h04) begin
            errors++;
            $display("FAIL eot_set: got eot=%b bytes=%0d, want eot=1 one byte 04", eot, got_q.size());
        end
        send_frame(rand_non_eot(), 1'b1);
        send_frame(rand_non_eot(), 1'b1);
        cycles(8);
        checks++;
        if (eot !== 1'b1 || rx_count !== cnt0 + 32'd3) begin
            errors++;
            $display("FAIL eot_sticky: got eot=%b cnt=%0d, want eot=1 cnt=%0d", eot, rx_count, cnt0 + 32'd3);
        end
    endtask

    task automatic test_overflow();
        int n;
        int acc;
        n = 5;
        do_reset();
        m_ready = 1'b0;
        got_q.delete();
        for (int i = 1; i <= n; i++) send_frame(8'(i), 1'b1);
        cycles(8);
        acc = (n < DEPTH) ? n : DEPTH;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_flag: got %b, want 1", overflow);
        end
        checks++;
        if (rx_count !== 32'(acc)) begin
            errors++;
            $display("FAIL ovf_count: got %0d, want %0d", rx_count, acc);
        end
        checks++;
        if (m_valid !== 1'b1 || m_data !== 8'h01 || got_q.size() != 0) begin
            errors++;
            $display("FAIL ovf_head: got valid=%b data=%h popped=%0d, want valid=1 data=01 popped=0",
                     m_valid, m_data, got_q.size());
        end
        m_ready = 1'b1;
        cycles(8);
        checks++;
        if (got_q.size() != acc) begin
            errors++;
            $display("FAIL ovf_drain_size: got %0d, want %0d", got_q.size(), acc);
        end else begin
            for (int i = 0; i < acc; i++) begin
                checks++;
                if (got_q[i] !== 8'(i + 1)) begin
                    errors++;
                    $display("FAIL ovf_drain[%0d]: got %h, want %h", i, got_q[i], 8'(i + 1));
                end
            end
        end
        checks++;
        if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty: got valid=%b, want 0", m_valid);
        end
    endtask

    task automatic test_framing();
        do_reset();
        m_ready = 1'b1;
        got_q.delete();
        send_frame(rand_non_eot(), 1'b0);
        cycles(8);
        urx = 1'b1;
        cycles(8);
        send_frame(8'h3C, 1'b1);
        cycles(8);
        checks++;
        if (framing_err !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL frame_flags: got fe=%b ov=%b, want fe=1 ov=0", framing_err, overflow);
        end
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h3C || rx_count !== 32'd1) begin
            errors++;
            $display("FAIL frame_bytes: got %0d bytes cnt=%0d, want one byte 3c cnt=1",
                     got_q.size(), rx_count);
        end
    endtask

    task automatic test_reset_midframe();
        m_ready = 1'b1;
        got_q.delete();
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rst_n = 1'b0;
        urx = 1'b0;
        #2;
        checks++;
        if ({m_valid, m_data, framing_err, overflow, eot, rx_count} !== 44'd0) begin
            errors++;
            $display("FAIL midrst_values: got valid=%b data=%h fe=%b ov=%b eot=%b cnt=%0d, want all 0",
                     m_valid, m_data, framing_err, overflow, eot, rx_count);
        end
        cycles(3);
        rst_n = 1'b1;
        cycles(12);
        urx = 1'b1;
        cycles(8);
        send_frame(8'h12, 1'b1);
        cycles(8);
        checks++;
        if (got_q.size() != 1 || got_q[0] !== 8'h12 || rx_count !== 32'd1) begin
            errors++;
            $display("FAIL midrst_next: got %0d bytes cnt=%0d, want one byte 12 cnt=1",
                     got_q.size(), rx_count);
        end
        checks++;
        if ({framing_err, overflow, eot} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_flags: got fe=%b ov=%b eot=%b, want 0", framing_err, overflow, eot);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        m_ready = 1'b1;
        got_q.delete();
        urx = 1'b0;
        cycles(1);
        urx = 1'b1;
        cycles(20);
        checks++;
        if (got_q.size() != 0 || rx_count !== 32'd0 || m_valid !== 1'b0) begin
            errors++;
            $display("FAIL glitch_push: got %0d bytes cnt=%0d valid=%b, want none",
                     got_q.size(), rx_count, m_valid);
        end
        checks++;
        if ({framing_err, overflow, eot} !== 3'b000) begin
            errors++;
            $display("FAIL glitch_flags: got fe=%b ov=%b eot=%b, want 0", framing_err, overflow, eot);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_eot();
        test_overflow();
        test_framing();
        test_reset_midframe();
        test_glitch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
